cdc_hs_rx: RTL and testbench
============================

// Module: cdc_hs_rx
// PURPOSE
//  Receive side of a four-phase req/ack clock-domain crossing, N channels, fully in the local (clk) domain.
//  Per channel: synchronise incoming req through STAGES flops; capture the sender-held bus into a local register.
//  Present captured word as valid/ready stream; return ack for the sender side to synchronise back.
//  Sits at the destination edge of every bundled-data crossing; replaces ad-hoc per-crossing req/ack sync pairs.
// PARAMETERS
//  W       32  data width per channel (>=1)
//  N       1   independent channels (>=1); channel i uses bits [i*W +: W]
//  STAGES  2   req synchroniser depth (>=2; elaboration error if <2)
// PORTS
//  clk         in   1    local clock
//  rst_n       in   1    asynchronous reset, active low
//  req_async   in   N    per-channel request from foreign domain (unsynchronised)
//  data_async  in   N*W  per-channel data, held stable by sender while req high
//  ack         out  N    per-channel acknowledge to foreign domain (registered, glitch-free)
//  out_valid   out  N    captured word available
//  out_ready   in   N    consumer accepts word
//  out_data    out  N*W  captured word, stable while out_valid high
// BEHAVIOUR
//  Reset (rst_n low, async): sync flops=0, state=IDLE, ack=0, out_valid=0, out_data=0, err=0.
//   Reset release while req_async high: channel starts a fresh transfer once req_s is seen high.
//  req_s[i] = last stage of channel-i synchroniser; all outputs driven from flops only.
//  Per-channel FSM, channels fully independent (no shared state/arbitration):
//   IDLE : req_s=1 -> capture data_async into out_data, out_valid<=1, -> VALID. else hold.
//   VALID: out_valid&&out_ready -> out_valid<=0, ack<=1, -> ACK. else hold (out_data frozen).
//   ACK  : req_s=0 -> ack<=0, -> IDLE. else hold ack=1.
//  Latency: req_async first sampled high at edge e0 -> out_valid high after edge e0+STAGES.
//   Handshake at edge e1 (valid&&ready) -> ack high after e1.
//   req_s low seen at edge e2 -> ack low after e2; next capture no earlier than e2+1.
//  Capture safety: data sampled only once req_s=1, i.e. >=STAGES cycles after req rose; sender owns hold.
//  ready with no valid: ignored. valid never drops without handshake (except error case below).
//  New req_s=1 while in VALID/ACK: no effect (protocol forbids; req cannot re-rise before ack falls).
//  req_s falls while VALID: see CONFIGURATION.
// CONFIGURATION
//  Macro CDC_HS_RX_ERR_EN (protocol-error detection):
//   defined: extra ports err out N (sticky) and err_clr in N.
//    req_s falls while VALID -> err[i]<=1, out_valid<=0, word discarded, ack stays 0, -> IDLE.
//    err_clr[i]=1 clears err[i] next edge; set and clear same cycle -> set wins.
//   undefined: no err/err_clr ports; req withdrawal in VALID ignored, word still delivered.
//    After handshake, ACK state sees req_s=0 -> ack pulses one cycle, -> IDLE.
// TESTING
//  STAGES=2,N=1: data_async=0xDEADBEEF, req_async 0->1 at e0, ready=1 -> out_valid rises after e0+2, out_data=0xDEADBEEF, ack high next edge.
//  Backpressure: ready=0 for 10 cycles -> out_valid/out_data held 10 cycles, ack=0 throughout; ready=1 -> ack 1.
//  N=4, staggered reqs with data 0x11..0x44, random ready -> each channel delivers own word once, acks independent.
//  Reset mid-VALID (rst_n low 1 cycle, async) -> out_valid=0, ack=0, out_data=0 immediately; with req still high, recapture after STAGES+1 cycles.
//  CDC_HS_RX_ERR_EN, drop req in VALID -> err=1, out_valid=0, ack never rises; err_clr pulse -> err=0.
//  Back-to-back 100 transfers, STAGES=3, random data -> scoreboard matches in order, no lost/dup words.

Source files
------------

// File: rtl/cdc_hs_rx_if.sv
// Bundled req/ack crossing, receive side: foreign-domain request/data in, local stream out.
// Interface only, no latency of its own.
// Backpressure travels on out_ready; the sender is held off by ack staying low.
//
// Signals (N channels, W bits per channel, channel i on bits [i*W +: W]):
//   req_async  : per-channel request from the foreign domain (unsynchronised)
//   data_async : per-channel data, held by the sender while its req is high
//   ack        : per-channel acknowledge back to the foreign domain
//   out_valid / out_ready / out_data : local valid/ready stream per channel
//   err / err_clr : sticky protocol-error flags and their clears (CDC_HS_RX_ERR_EN only)
// The master modport is the environment (sender plus consumer). The slave modport is cdc_hs_rx.
interface cdc_hs_rx_if #(
    parameter int W = 32,
    parameter int N = 1
);
    logic [N-1:0]   req_async;
    logic [N*W-1:0] data_async;
    logic [N-1:0]   ack;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
`ifdef CDC_HS_RX_ERR_EN
    logic [N-1:0]   err;
    logic [N-1:0]   err_clr;

    modport master (
        output req_async, data_async, out_ready, err_clr,
        input  ack, out_valid, out_data, err
    );
    modport slave (
        input  req_async, data_async, out_ready, err_clr,
        output ack, out_valid, out_data, err
    );
`else
    modport master (
        output req_async, data_async, out_ready,
        input  ack, out_valid, out_data
    );
    modport slave (
        input  req_async, data_async, out_ready,
        output ack, out_valid, out_data
    );
`endif
endinterface

// File: rtl/cdc_hs_rx.sv
// Four-phase req/ack CDC receiver with N independent channels, all logic in the clk domain.
// Latency: req_async is first sampled at edge e0. out_valid rises after edge e0+STAGES, and ack rises one edge after the handshake.
// Backpressure: a word is held in VALID until out_ready. ack is withheld meanwhile, so the sender stalls.
//
// Ports:
//   clk   : local clock
//   rst_n : asynchronous reset, active low
//   bus   : cdc_hs_rx_if.slave. It carries req_async, data_async, ack, out_valid, out_ready and out_data.
//           It also carries err and err_clr when CDC_HS_RX_ERR_EN is defined.
// Optional feature macro: CDC_HS_RX_ERR_EN
//   When defined, the channel flags a sticky error if the sender withdraws req before its word is accepted.
//   When undefined, that withdrawal is ignored and the word is still delivered.
// Parameters: W data width per channel, N channel count, STAGES req synchroniser depth (>=2).
module cdc_hs_rx #(
    parameter int W      = 32,
    parameter int N      = 1,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    cdc_hs_rx_if.slave bus
);

    if (STAGES < 2) begin : g_bad_stages
        $error("cdc_hs_rx: STAGES must be >= 2");
    end
    if (W < 1 || N < 1) begin : g_bad_size
        $error("cdc_hs_rx: W and N must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    logic [STAGES-1:0] sync_q [N];
    logic [N-1:0]      req_s;

    state_e            state_q [N];
    state_e            state_d [N];
    logic [N-1:0]      vld_q, vld_d;
    logic [N-1:0]      ack_q, ack_d;
    logic [N*W-1:0]    dat_q, dat_d;
`ifdef CDC_HS_RX_ERR_EN
    logic [N-1:0]      err_q, err_d;
`endif

    // The last synchroniser stage is the only view of req that the FSM uses.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N; i++) begin
            req_s[i] = sync_q[i][STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
            vld_q <= '0;
            ack_q <= '0;
            dat_q <= '0;
`ifdef CDC_HS_RX_ERR_EN
            err_q <= '0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i]  <= {sync_q[i][STAGES-2:0], bus.req_async[i]};
                state_q[i] <= state_d[i];
            end
            vld_q <= vld_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
`ifdef CDC_HS_RX_ERR_EN
            err_q <= err_d;
`endif
        end
    end

    always_comb begin
        vld_d = vld_q;
        ack_d = ack_q;
        dat_d = dat_q;
`ifdef CDC_HS_RX_ERR_EN
        // Clear is applied first so that a same-cycle set below overrides it.
        err_d = err_q & ~bus.err_clr;
`endif
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    // req_s high means the sender's data has been stable for >= STAGES cycles.
                    if (req_s[i]) begin
                        dat_d[i*W +: W] = bus.data_async[i*W +: W];
                        vld_d[i]        = 1'b1;
                        state_d[i]      = ST_VALID;
                    end
                end
                ST_VALID: begin
                    // A handshake in the same cycle as a req withdrawal still counts as delivered.
                    // The consumer has already taken the word, so it goes to ACK.
                    if (bus.out_ready[i]) begin
                        vld_d[i]   = 1'b0;
                        ack_d[i]   = 1'b1;
                        state_d[i] = ST_ACK;
                    end
`ifdef CDC_HS_RX_ERR_EN
                    else if (!req_s[i]) begin
                        vld_d[i]   = 1'b0;
                        err_d[i]   = 1'b1;
                        state_d[i] = ST_IDLE;
                    end
`endif
                end
                ST_ACK: begin
                    if (!req_s[i]) begin
                        ack_d[i]   = 1'b0;
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    vld_d[i]   = 1'b0;
                    ack_d[i]   = 1'b0;
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.ack       = ack_q;
    assign bus.out_data  = dat_q;
`ifdef CDC_HS_RX_ERR_EN
    assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: single-channel latency/backpressure/reset, 4-channel staggered, 100-word stream.
// Inputs are driven and outputs sampled 1 time unit after each rising clk edge.
// Run with CDC_HS_RX_ERR_EN defined to exercise the protocol-error path.
module tb_cdc_hs_rx;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    cdc_hs_rx_if #(.W(32), .N(1)) ifa ();
    cdc_hs_rx_if #(.W(32), .N(4)) ifb ();

    cdc_hs_rx #(.W(32), .N(1), .STAGES(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    cdc_hs_rx #(.W(32), .N(4), .STAGES(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the bench must always terminate.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  hs;
        int          sst [4];
        int          cnt [4];
        logic [31:0] q [$];
        logic [31:0] d;
        int          sent;
        int          got;
        bit          busy;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ifa.req_async  = '0;
        ifa.data_async = '0;
        ifa.out_ready  = '0;
        ifb.req_async  = '0;
        ifb.data_async = '0;
        ifb.out_ready  = '0;
`ifdef CDC_HS_RX_ERR_EN
        ifa.err_clr = '0;
        ifb.err_clr = '0;
`endif
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_ack",   ifa.ack,       0);
        chk("rst_data",  ifa.out_data,  0);
        chk("rst_b_valid", ifb.out_valid, 0);
`ifdef CDC_HS_RX_ERR_EN
        chk("rst_err", ifa.err, 0);
`endif
        rst_n = 1'b1;
        tick();

        // ---- basic transfer, STAGES=2: valid after e0+2, ack one edge after handshake ----
        ifa.data_async = 32'hDEADBEEF;
        ifa.req_async  = 1'b1;
        ifa.out_ready  = 1'b1;
        tick();                                  // after e0
        chk("lat_e0_valid", ifa.out_valid, 0);
        tick();                                  // after e0+1
        chk("lat_e1_valid", ifa.out_valid, 0);
        tick();                                  // after e0+2
        chk("lat_e2_valid", ifa.out_valid, 1);
        chk("lat_e2_data",  ifa.out_data,  32'hDEADBEEF);
        chk("lat_e2_ack",   ifa.ack,       0);
        tick();                                  // handshake at e0+3
        chk("hs_valid", ifa.out_valid, 0);
        chk("hs_ack",   ifa.ack,       1);
        ifa.req_async = 1'b0;
        tick();
        chk("ackhold1", ifa.ack, 1);
        tick();
        chk("ackhold2", ifa.ack, 1);
        tick();
        chk("ackfall",  ifa.ack, 0);

        // ---- backpressure: 10 cycles of ready=0, output frozen even if the bus changes ----
        ifa.out_ready  = 1'b0;
        ifa.data_async = 32'h12345678;
        ifa.req_async  = 1'b1;
        repeat (3) tick();
        chk("bp_valid", ifa.out_valid, 1);
        ifa.data_async = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_valid", ifa.out_valid, 1);
            chk("bp_hold_data",  ifa.out_data,  32'h12345678);
            chk("bp_hold_ack",   ifa.ack,       0);
        end
        ifa.out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", ifa.out_valid, 0);
        chk("bp_rel_ack",   ifa.ack,       1);
        ifa.out_ready = 1'b0;
        ifa.req_async = 1'b0;
        repeat (3) tick();
        chk("bp_ackfall", ifa.ack, 0);

        // ---- async reset mid-VALID, req kept high: recapture after STAGES+1 edges ----
        ifa.data_async = 32'hCAFEF00D;
        ifa.req_async  = 1'b1;
        repeat (3) tick();
        chk("rstm_pre_valid", ifa.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", ifa.out_valid, 0);
        chk("rstm_ack",   ifa.ack,       0);
        chk("rstm_data",  ifa.out_data,  0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstm_r1_valid", ifa.out_valid, 0);
        tick();
        chk("rstm_r2_valid", ifa.out_valid, 0);
        tick();
        chk("rstm_r3_valid", ifa.out_valid, 1);
        chk("rstm_r3_data",  ifa.out_data,  32'hCAFEF00D);
        ifa.out_ready = 1'b1;
        tick();
        chk("rstm_ack1", ifa.ack, 1);
        ifa.out_ready = 1'b0;
        ifa.req_async = 1'b0;
        repeat (4) tick();
        chk("rstm_ack0", ifa.ack, 0);

        // ---- req withdrawn while VALID ----
        ifa.data_async = 32'h0BADF00D;
        ifa.req_async  = 1'b1;
        repeat (3) tick();
        chk("wd_valid", ifa.out_valid, 1);
        ifa.req_async = 1'b0;
`ifdef CDC_HS_RX_ERR_EN
        tick();
        chk("err_w1_valid", ifa.out_valid, 1);
        chk("err_w1_err",   ifa.err,       0);
        tick();
        chk("err_w2_valid", ifa.out_valid, 1);
        tick();
        chk("err_valid", ifa.out_valid, 0);
        chk("err_set",   ifa.err,       1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("err_noack", ifa.ack, 0);
            chk("err_stick", ifa.err, 1);
        end
        ifa.err_clr = 1'b1;
        tick();
        ifa.err_clr = 1'b0;
        chk("err_clr", ifa.err, 0);
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wd_hold_valid", ifa.out_valid, 1);
            chk("wd_hold_data",  ifa.out_data,  32'h0BADF00D);
        end
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        chk("wd_hs_valid", ifa.out_valid, 0);
        chk("wd_pulse_hi", ifa.ack,       1);
        tick();
        chk("wd_pulse_lo", ifa.ack,       0);
        tick();
        chk("wd_no_recap", ifa.out_valid, 0);
`endif

        // ---- N=4, STAGES=3: staggered requests 0x11..0x44, random ready ----
        for (int c = 0; c < 4; c++) begin
            sst[c] = 0;
            cnt[c] = 0;
        end
        for (int cyc = 0; cyc < 80; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (cyc == 2 * c) begin
                    ifb.data_async[c*32 +: 32] = 32'h11 * (c + 1);
                    ifb.req_async[c] = 1'b1;
                    sst[c] = 1;
                end else if (sst[c] == 1 && ifb.ack[c]) begin
                    ifb.req_async[c] = 1'b0;
                    sst[c] = 2;
                end
            end
            ifb.out_ready = 4'($urandom_range(0, 15));
            hs = ifb.out_valid & ifb.out_ready;
            for (int c = 0; c < 4; c++) begin
                if (hs[c]) begin
                    cnt[c]++;
                    chk("mc_data", ifb.out_data[c*32 +: 32], 32'h11 * (c + 1));
                end
            end
            tick();
            for (int c = 0; c < 4; c++) begin
                if (hs[c]) chk("mc_ack", ifb.ack[c], 1);
            end
        end
        for (int c = 0; c < 4; c++) begin
            chk("mc_count", cnt[c], 1);
        end
        chk("mc_idle_ack",   ifb.ack,       0);
        chk("mc_idle_valid", ifb.out_valid, 0);
        ifb.out_ready = '0;

        // ---- 100 back-to-back transfers on channel 0, scoreboard in order ----
        sent = 0;
        got  = 0;
        busy = 1'b0;
        for (int cyc = 0; cyc < 6000 && got < 100; cyc++) begin
            if (!busy && !ifb.ack[0] && sent < 100) begin
                d = $urandom;
                ifb.data_async[31:0] = d;
                ifb.req_async[0]     = 1'b1;
                q.push_back(d);
                sent++;
                busy = 1'b1;
            end else if (busy && ifb.ack[0]) begin
                ifb.req_async[0]     = 1'b0;
                ifb.data_async[31:0] = $urandom;
                busy = 1'b0;
            end
            ifb.out_ready[0] = 1'($urandom_range(0, 1));
            if (ifb.out_valid[0] && ifb.out_ready[0]) begin
                chk("b2b_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    d = q.pop_front();
                    chk("b2b_data", ifb.out_data[31:0], d);
                end
                got++;
            end
            tick();
        end
        chk("b2b_count", got, 100);
        chk("b2b_left",  q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
